// File: rtl/inst_stream_loader_if.sv
// Byte-stream input and instruction-BRAM port A write bus shared by inst_stream_loader and its environment.
interface inst_stream_loader_if;
  logic        en;
  logic [7:0]  data;
  logic [31:0] inst_addra;
  logic [31:0] inst_dina;
  logic [3:0]  inst_wea;

  // master is the loader itself: it consumes the bytes and drives the BRAM write port
  modport master (input en, data, output inst_addra, inst_dina, inst_wea);
  modport slave  (output en, data, input inst_addra, inst_dina, inst_wea);
endinterface

// File: rtl/inst_stream_loader.sv
// Loads a length-prefixed byte stream into instruction BRAM as big-endian 32-bit words.
// Define BOOT_CHECKSUM_EN to require a trailing 32-bit sum of the loaded words.
module inst_stream_loader #(
  parameter int DEPTH_WORDS = 16384,
  parameter int CNT_W       = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  inst_stream_loader_if.master bus,
  output logic [CNT_W-1:0]     loaded_words,
  output logic                 done,
  output logic                 overflow,
  output logic                 csum_err
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, LOAD, CHK, DONE, ERR} state_t;
  localparam state_t END_ST = CHK;
`else
  typedef enum logic [2:0] {HDR, LOAD, DONE, ERR} state_t;
  localparam state_t END_ST = DONE;
`endif

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] length;
  logic [31:0] asm_word;
  logic [31:0] next_word;
  logic        accepting;
  logic        last_byte;
  logic        write_last;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum;
  logic        csum_err_r;

  assign accepting = (state == HDR) || (state == LOAD) || (state == CHK);
  assign csum_err  = csum_err_r;
`else
  assign accepting = (state == HDR) || (state == LOAD);
  assign csum_err  = 1'b0;
`endif

  assign next_word  = {asm_word[23:0], bus.data};
  assign last_byte  = bus.en && accepting && (byte_cnt == 2'd3);
  assign write_last = (32'(loaded_words) + 32'd1) == length;

  // Packing runs continuously across states, so a byte arriving during the write cycle
  // (or the first checksum byte right after the last word) is never lost.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state        <= HDR;
      byte_cnt     <= '0;
      length       <= '0;
      asm_word     <= '0;
      loaded_words <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      bus.inst_wea <= 4'h0;
`ifdef BOOT_CHECKSUM_EN
      sum          <= '0;
      csum_err_r   <= 1'b0;
`endif
      if (!rstn) begin
        bus.inst_addra <= '0;
        bus.inst_dina  <= '0;
      end
    end else begin
      bus.inst_wea <= 4'h0;

      if (bus.en && accepting) begin
        asm_word <= next_word;
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (bus.inst_wea != 4'h0) begin
        loaded_words <= loaded_words + CNT_W'(1);
        if (write_last) begin
          state <= END_ST;
          done  <= (END_ST == DONE);
        end
      end

      unique case (state)
        HDR: begin
          if (last_byte) begin
            length <= next_word;
            if (next_word > 32'(DEPTH_WORDS)) begin
              overflow <= 1'b1;
              state    <= ERR;
            end else if (next_word == 32'd0) begin
              state <= END_ST;
              done  <= (END_ST == DONE);
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (last_byte) begin
            bus.inst_wea   <= 4'hF;
            bus.inst_dina  <= next_word;
            bus.inst_addra <= 32'({loaded_words, 2'b00});
`ifdef BOOT_CHECKSUM_EN
            sum <= sum + next_word;
`endif
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CHK: begin
          if (last_byte) begin
            done       <= 1'b1;
            csum_err_r <= (sum != next_word);
            state      <= DONE;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_stream_loader.sv
// Self-checking bench for inst_stream_loader: table vectors, corner-case sequences and
// randomized streams checked against a stream-level model of the loader.
module tb_inst_stream_loader;
  localparam int DEPTH_WORDS = 16384;
  localparam int CNT_W       = 15;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wea;
    int          cycle;
  } wr_t;

  typedef struct {
    logic [31:0] hdr;
    int          words;
    int          gap;
    int          extra;
    logic        exp_ovf;
    logic        exp_done;
    int          exp_lw;
  } vec_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] loaded_words;
  logic             done;
  logic             overflow;
  logic             csum_err;

  inst_stream_loader_if bus();

  inst_stream_loader #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (clear),
    .bus         (bus),
    .loaded_words(loaded_words),
    .done        (done),
    .overflow    (overflow),
    .csum_err    (csum_err)
  );

  always #5 clk = ~clk;

  int  cycle_cnt = 0;
  int  done_cycle = -1;
  wr_t wr_q[$];
  int  byte_cyc[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Every cycle with a nonzero write enable is logged as one BRAM write
  always @(negedge clk) begin
    if (bus.inst_wea != 4'h0)
      wr_q.push_back('{bus.inst_addra, bus.inst_dina, bus.inst_wea, cycle_cnt});
    if (done && done_cycle < 0)
      done_cycle = cycle_cnt;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rstn     = 1'b0;
    clear    = 1'b0;
    bus.en   = 1'b0;
    bus.data = 8'h00;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic void startRun();
    wr_q.delete();
    byte_cyc.delete();
    done_cycle = -1;
  endfunction

  task automatic pushWord(inout byte_q_t q, input logic [31:0] w);
    q.push_back(w[31:24]);
    q.push_back(w[23:16]);
    q.push_back(w[15:8]);
    q.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] pack4(input byte_q_t q, input int i);
    return {q[i], q[i+1], q[i+2], q[i+3]};
  endfunction

  // Drives one byte per en pulse; called and returns on a falling edge
  task automatic applyStimulus(input byte_q_t bytes, input int gap, input bit rand_gap);
    foreach (bytes[i]) begin
      bus.en   = 1'b1;
      bus.data = bytes[i];
      byte_cyc.push_back(cycle_cnt);
      @(negedge clk);
      bus.en = 1'b0;
      if (rand_gap) repeat ($urandom_range(2)) @(negedge clk);
      else repeat (gap) @(negedge clk);
    end
  endtask

  // Reference: derive the expected writes and final status from the stream alone
  task automatic checkRun(input string name, input byte_q_t bytes);
    wr_t         exp_q[$];
    logic [31:0] len;
    logic [31:0] sum;
    int          avail;
    int          nw;
    logic        e_done;
    logic        e_ovf;
    logic        e_csum;
    int          e_done_cyc;
    e_done = 1'b0; e_ovf = 1'b0; e_csum = 1'b0; e_done_cyc = -1;
    sum = 32'd0; nw = 0;
    repeat (4) @(negedge clk);
    if (bytes.size() >= 4) begin
      len = pack4(bytes, 0);
      if (len > 32'(DEPTH_WORDS)) begin
        e_ovf = 1'b1;
      end else begin
        avail = (bytes.size() - 4) / 4;
        nw = (avail < int'(len)) ? avail : int'(len);
        for (int k = 0; k < nw; k++) begin
          wr_t w;
          w.data  = pack4(bytes, 4 + 4*k);
          w.addr  = 32'(4*k);
          w.wea   = 4'hF;
          w.cycle = byte_cyc[4 + 4*k + 3] + 1;
          sum += w.data;
          exp_q.push_back(w);
        end
        if (nw == int'(len)) begin
`ifdef BOOT_CHECKSUM_EN
          int base;
          base = 4 + 4*nw;
          if (bytes.size() >= base + 4) begin
            e_done     = 1'b1;
            e_done_cyc = byte_cyc[base + 3] + 1;
            e_csum     = (pack4(bytes, base) != sum);
          end
`else
          e_done     = 1'b1;
          e_done_cyc = (nw == 0) ? byte_cyc[3] + 1 : exp_q[nw-1].cycle + 1;
`endif
        end
      end
    end
    checkOutput($sformatf("%s write count", name), 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wr_q.size()) begin
        checkOutput($sformatf("%s wr%0d addr", name, k), wr_q[k].addr, exp_q[k].addr);
        checkOutput($sformatf("%s wr%0d data", name, k), wr_q[k].data, exp_q[k].data);
        checkOutput($sformatf("%s wr%0d wea", name, k), 32'(wr_q[k].wea), 32'(exp_q[k].wea));
        checkOutput($sformatf("%s wr%0d cycle", name, k), 32'(wr_q[k].cycle), 32'(exp_q[k].cycle));
      end
    end
    checkOutput($sformatf("%s loaded_words", name), 32'(loaded_words), 32'(nw));
    checkOutput($sformatf("%s done", name), 32'(done), 32'(e_done));
    checkOutput($sformatf("%s overflow", name), 32'(overflow), 32'(e_ovf));
    checkOutput($sformatf("%s csum_err", name), 32'(csum_err), 32'(e_csum));
    if (e_done)
      checkOutput($sformatf("%s done cycle", name), 32'(done_cycle), 32'(e_done_cyc));
  endtask

  task automatic checkResetState(input string name);
    checkOutput($sformatf("%s addra", name), bus.inst_addra, 32'h0);
    checkOutput($sformatf("%s dina", name), bus.inst_dina, 32'h0);
    checkOutput($sformatf("%s wea", name), 32'(bus.inst_wea), 32'h0);
    checkOutput($sformatf("%s loaded_words", name), 32'(loaded_words), 32'h0);
    checkOutput($sformatf("%s done", name), 32'(done), 32'h0);
    checkOutput($sformatf("%s overflow", name), 32'(overflow), 32'h0);
    checkOutput($sformatf("%s csum_err", name), 32'(csum_err), 32'h0);
  endtask

  initial begin
    vec_t        vecs[8];
    byte_q_t     q;
    logic [31:0] sum;
    logic [31:0] w;

    vecs[0] = '{32'd2,       2, 3, 0, 1'b0, 1'b1, 2};
    vecs[1] = '{32'd2,       2, 0, 4, 1'b0, 1'b1, 2};
    vecs[2] = '{32'h00004001, 2, 0, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{32'd0,       0, 1, 4, 1'b0, 1'b1, 0};
    vecs[4] = '{32'd3,       2, 0, 0, 1'b0, 1'b0, 2};
    vecs[5] = '{32'h00004000, 1, 0, 0, 1'b0, 1'b0, 1};
    vecs[6] = '{32'd1,       1, 2, 0, 1'b0, 1'b1, 1};
    vecs[7] = '{32'h10000000, 1, 1, 3, 1'b1, 1'b0, 0};

    doReset();
    @(negedge clk);
    checkResetState("reset");

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      doReset();
      startRun();
      q.delete();
      sum = 32'd0;
      pushWord(q, vecs[v].hdr);
      for (int k = 0; k < vecs[v].words; k++) begin
        w = $urandom;
        pushWord(q, w);
        sum += w;
      end
`ifdef BOOT_CHECKSUM_EN
      if (vecs[v].hdr <= 32'(DEPTH_WORDS) && 32'(vecs[v].words) >= vecs[v].hdr)
        pushWord(q, sum);
`endif
      for (int k = 0; k < vecs[v].extra; k++) q.push_back(8'($urandom));
      applyStimulus(q, vecs[v].gap, 1'b0);
      checkRun($sformatf("vec%0d", v), q);
      checkOutput($sformatf("vec%0d table overflow", v), 32'(overflow), 32'(vecs[v].exp_ovf));
      checkOutput($sformatf("vec%0d table done", v), 32'(done), 32'(vecs[v].exp_done));
      checkOutput($sformatf("vec%0d table loaded_words", v), 32'(loaded_words), 32'(vecs[v].exp_lw));
    end

    // Two-word program, spaced bytes then back-to-back bytes
    for (int g = 0; g < 2; g++) begin
      doReset();
      startRun();
      q.delete();
      pushWord(q, 32'd2);
      pushWord(q, 32'hDEADBEEF);
      pushWord(q, 32'h01020304);
`ifdef BOOT_CHECKSUM_EN
      pushWord(q, 32'hDEADBEEF + 32'h01020304);
`endif
      applyStimulus(q, (g == 0) ? 3 : 0, 1'b0);
      checkRun($sformatf("plan%0d", g), q);
      if (wr_q.size() >= 2) begin
        checkOutput($sformatf("plan%0d word0", g), wr_q[0].data, 32'hDEADBEEF);
        checkOutput($sformatf("plan%0d addr1", g), wr_q[1].addr, 32'h4);
        checkOutput($sformatf("plan%0d word1", g), wr_q[1].data, 32'h01020304);
      end
    end

    // clear: after a complete load, with a 4th byte, during a write, and after overflow
    doReset();
    startRun();
    q.delete();
    pushWord(q, 32'd1);
    pushWord(q, 32'h55667788);
`ifdef BOOT_CHECKSUM_EN
    pushWord(q, 32'h55667788);
`endif
    applyStimulus(q, 0, 1'b0);
    checkRun("preclear", q);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear done", 32'(done), 32'h0);
    checkOutput("clear loaded_words", 32'(loaded_words), 32'h0);

    startRun();
    q.delete();
    pushWord(q, 32'd1);
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    applyStimulus(q, 0, 1'b0);
    bus.en   = 1'b1;
    bus.data = 8'h44;
    clear    = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("clear+en write count", 32'(wr_q.size()), 32'h0);
    checkOutput("clear+en loaded_words", 32'(loaded_words), 32'h0);

    startRun();
    q.delete();
    pushWord(q, 32'd1);
    pushWord(q, 32'hAABBCCDD);
`ifdef BOOT_CHECKSUM_EN
    pushWord(q, 32'hAABBCCDD);
`endif
    applyStimulus(q, 0, 1'b0);
    checkRun("postclear", q);

    doReset();
    startRun();
    q.delete();
    pushWord(q, 32'd1);
    pushWord(q, 32'h12345678);
    applyStimulus(q, 0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear pending wea", 32'(bus.inst_wea), 32'h0);
    checkOutput("clear pending loaded_words", 32'(loaded_words), 32'h0);
    checkOutput("clear pending done", 32'(done), 32'h0);

    startRun();
    q.delete();
    pushWord(q, 32'h00004001);
    applyStimulus(q, 0, 1'b0);
    @(negedge clk);
    checkOutput("ovf before clear", 32'(overflow), 32'h1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("ovf after clear", 32'(overflow), 32'h0);

    // Reset in the middle of the third word of a three-word program
    doReset();
    startRun();
    q.delete();
    pushWord(q, 32'd3);
    pushWord(q, 32'hA1A2A3A4);
    pushWord(q, 32'hB1B2B3B4);
    q.push_back(8'hC1);
    q.push_back(8'hC2);
    q.push_back(8'hC3);
    applyStimulus(q, 1, 1'b0);
    checkOutput("midword prewrites", 32'(wr_q.size()), 32'd2);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkResetState("midword reset");
    repeat (3) @(negedge clk);
    checkOutput("midword no write", 32'(wr_q.size()), 32'd2);
    startRun();
    q.delete();
    pushWord(q, 32'd1);
    pushWord(q, 32'hCAFEF00D);
`ifdef BOOT_CHECKSUM_EN
    pushWord(q, 32'hCAFEF00D);
`endif
    applyStimulus(q, 0, 1'b0);
    checkRun("after reset", q);

`ifdef BOOT_CHECKSUM_EN
    for (int c = 0; c < 2; c++) begin
      doReset();
      startRun();
      q.delete();
      pushWord(q, 32'd2);
      pushWord(q, 32'h00000001);
      pushWord(q, 32'hFFFFFFFF);
      pushWord(q, 32'(c));
      applyStimulus(q, 0, 1'b0);
      checkRun($sformatf("csum%0d", c), q);
      checkOutput($sformatf("csum%0d err const", c), 32'(csum_err), 32'(c));
    end
`endif

    // Randomized streams
    for (int r = 0; r < 20; r++) begin
      logic [31:0] len;
      int          nwords;
      doReset();
      startRun();
      q.delete();
      sum = 32'd0;
      if ($urandom_range(6) == 0) len = 32'(DEPTH_WORDS + 1) + $urandom_range(500);
      else len = $urandom_range(5);
      nwords = (len > 32'(DEPTH_WORDS)) ? 2 : int'(len);
      if ($urandom_range(4) == 0 && nwords > 0) nwords--;
      pushWord(q, len);
      for (int k = 0; k < nwords; k++) begin
        w = $urandom;
        pushWord(q, w);
        sum += w;
      end
`ifdef BOOT_CHECKSUM_EN
      if (nwords == int'(len)) pushWord(q, ($urandom_range(1) == 0) ? sum : sum + 32'd1);
`endif
      repeat ($urandom_range(5)) q.push_back(8'($urandom));
      applyStimulus(q, 0, 1'b1);
      checkRun($sformatf("rand%0d", r), q);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
